// File: rtl/lmb_bram_pkg.sv
// Shared constants and elaboration-time helpers for the LMB dual-port BRAM.
package lmb_bram_pkg;

  localparam int BYTE_W = 8;

  localparam string RDW_WRITE_FIRST = "WRITE_FIRST";
  localparam string RDW_READ_FIRST  = "READ_FIRST";

  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned x;
    r = 32'sd0;
    x = 32'd1;
    while (x < v) begin
      x = x << 1;
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Geometry and latency legality; base alignment and mode strings are checked in the top.
  function automatic bit params_ok(input int unsigned memsize, input int dwidth,
                                   input int num_we, input int latency);
    return is_pow2(memsize) &&
           ((dwidth % BYTE_W) == 32'sd0) && (dwidth > 32'sd0) &&
           (num_we == dwidth / BYTE_W) &&
           (memsize >= unsigned'(num_we)) &&
           ((latency == 32'sd1) || (latency == 32'sd2));
  endfunction

endpackage

// File: rtl/lmb_bram_port_pipe.sv
// Per-port read pipeline: one or two register stages for Din/Valid/AddrErr.
module lmb_bram_port_pipe
  import lmb_bram_pkg::*;
#(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_acc,
  input  logic          i_hit,
  input  logic [DW-1:0] i_rdata,
  output logic [DW-1:0] o_din,
  output logic          o_valid,
  output logic          o_err
);

  logic [DW-1:0] r_din1;
  logic          r_valid1;
  logic          r_err1;

  // First stage captures the array word (or zero on a miss); data holds between accesses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_din1   <= '0;
      r_valid1 <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_valid1 <= i_acc;
      r_err1   <= i_acc & ~i_hit;
      if (i_acc) begin
        r_din1 <= i_hit ? i_rdata : '0;
      end
    end
  end

  if (LAT == 2) begin : g_lat2
    logic [DW-1:0] r_din2;
    logic          r_valid2;
    logic          r_err2;

    // Second stage re-times the first without changing throughput.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_din2   <= '0;
        r_valid2 <= 1'b0;
        r_err2   <= 1'b0;
      end else begin
        r_valid2 <= r_valid1;
        r_err2   <= r_err1;
        if (r_valid1) begin
          r_din2 <= r_din1;
        end
      end
    end

    assign o_din   = r_din2;
    assign o_valid = r_valid2;
    assign o_err   = r_err2;
  end else begin : g_lat1
    assign o_din   = r_din1;
    assign o_valid = r_valid1;
    assign o_err   = r_err1;
  end

endmodule

// File: rtl/lmb_bram_dp_pipelined.sv
// Parametrised true-dual-port LMB BRAM on a single clock: decode, byte-lane
// writes with port-A priority, selectable read-during-write and a collision flag.
module lmb_bram_dp_pipelined
  import lmb_bram_pkg::*;
#(
  parameter int unsigned                C_MEMSIZE      = 32'h10000,
  parameter int                         C_PORT_DWIDTH  = 32,
  parameter int                         C_PORT_AWIDTH  = 32,
  parameter int                         C_NUM_WE       = C_PORT_DWIDTH / 8,
  parameter logic [C_PORT_AWIDTH-1:0]   C_BASEADDR     = '0,
  parameter int                         C_READ_LATENCY = 1,
  parameter string                      C_RDW_MODE     = "WRITE_FIRST",
  parameter string                      C_FAMILY       = "spartan6"
) (
  input  logic                   BRAM_Clk,
  input  logic                   BRAM_Rst,
  input  logic                   BRAM_EN_A,
  input  logic [0:C_NUM_WE-1]      BRAM_WEN_A,
  input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Din_A,
  output logic                   BRAM_Valid_A,
  output logic                   BRAM_AddrErr_A,
  input  logic                   BRAM_EN_B,
  input  logic [0:C_NUM_WE-1]      BRAM_WEN_B,
  input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Din_B,
  output logic                   BRAM_Valid_B,
  output logic                   BRAM_AddrErr_B,
  output logic                   BRAM_Collision
);

  localparam int MEM_AW  = clog2(C_MEMSIZE);
  localparam int LANE_AW = clog2(C_NUM_WE);
  localparam int IDX_W   = (MEM_AW > LANE_AW) ? (MEM_AW - LANE_AW) : 1;
  localparam int DEPTH   = 1 << IDX_W;
  localparam logic [C_PORT_AWIDTH-1:0] ADDR_MASK = C_PORT_AWIDTH'(C_MEMSIZE - 32'd1);
  localparam bit WRITE_FIRST = (C_RDW_MODE == RDW_WRITE_FIRST);

  if (!params_ok(C_MEMSIZE, C_PORT_DWIDTH, C_NUM_WE, C_READ_LATENCY)) begin : g_bad_geometry
    $error("lmb_bram_dp_pipelined: illegal C_MEMSIZE/C_PORT_DWIDTH/C_NUM_WE/C_READ_LATENCY");
  end
  if ((C_BASEADDR & ADDR_MASK) != '0) begin : g_bad_base
    $error("lmb_bram_dp_pipelined: C_BASEADDR not aligned to C_MEMSIZE");
  end
  if (((C_RDW_MODE != RDW_WRITE_FIRST) && (C_RDW_MODE != RDW_READ_FIRST)) || (C_FAMILY == "")) begin : g_bad_mode
    $error("lmb_bram_dp_pipelined: illegal C_RDW_MODE or empty C_FAMILY");
  end

  function automatic logic [C_PORT_DWIDTH-1:0] merge_lanes(input logic [C_PORT_DWIDTH-1:0] old_w,
                                                           input logic [C_PORT_DWIDTH-1:0] new_w,
                                                           input logic [C_NUM_WE-1:0]      wen);
    logic [C_PORT_DWIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < C_NUM_WE; i++) begin
      if (wen[i]) begin
        res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
      end else begin
        res[i*BYTE_W +: BYTE_W] = old_w[i*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

  logic [C_PORT_DWIDTH-1:0] r_mem [DEPTH];
  logic                     r_collision;

  // Ascending port ranges assign MSB-to-MSB, so WEN bit 0 lands on the top lane.
  logic [C_PORT_AWIDTH-1:0] w_addr_a, w_addr_b;
  logic [C_NUM_WE-1:0]      w_wen_a, w_wen_b;
  logic [C_PORT_DWIDTH-1:0] w_wdat_a, w_wdat_b, w_old_a, w_old_b;
  logic [C_PORT_DWIDTH-1:0] w_new_a, w_new_b, w_arr_a, w_raw_a, w_raw_b, w_din_a, w_din_b;
  logic [IDX_W-1:0]         w_idx_a, w_idx_b;
  logic                     w_acc_a, w_acc_b, w_hit_a, w_hit_b, w_wr_a, w_wr_b, w_same;

  assign w_addr_a = BRAM_Addr_A;
  assign w_addr_b = BRAM_Addr_B;
  assign w_wen_a  = BRAM_WEN_A;
  assign w_wen_b  = BRAM_WEN_B;
  assign w_wdat_a = BRAM_Dout_A;
  assign w_wdat_b = BRAM_Dout_B;

  assign w_acc_a = BRAM_EN_A & ~BRAM_Rst;
  assign w_acc_b = BRAM_EN_B & ~BRAM_Rst;
  assign w_hit_a = (w_addr_a & ~ADDR_MASK) == C_BASEADDR;
  assign w_hit_b = (w_addr_b & ~ADDR_MASK) == C_BASEADDR;
  assign w_idx_a = w_addr_a[LANE_AW +: IDX_W];
  assign w_idx_b = w_addr_b[LANE_AW +: IDX_W];
  assign w_wr_a  = w_acc_a & w_hit_a & (|w_wen_a);
  assign w_wr_b  = w_acc_b & w_hit_b & (|w_wen_b);
  assign w_same  = w_acc_a & w_acc_b & w_hit_a & w_hit_b & (w_idx_a == w_idx_b);

  assign w_old_a = r_mem[w_idx_a];
  assign w_old_b = r_mem[w_idx_b];
  assign w_new_a = merge_lanes(w_old_a, w_wdat_a, w_wen_a);
  assign w_new_b = merge_lanes(w_old_b, w_wdat_b, w_wen_b);
  // On a shared word, A's merge starts from B's result so A wins only on its own lanes.
  assign w_arr_a = merge_lanes((w_same & w_wr_b) ? w_new_b : w_old_a, w_wdat_a, w_wen_a);

  // The other port always sees the pre-write word; only the own port honours WRITE_FIRST.
  assign w_raw_a = WRITE_FIRST ? w_new_a : w_old_a;
  assign w_raw_b = WRITE_FIRST ? w_new_b : w_old_b;

  // Array update; B is applied first so A's already-merged word is the final value.
  always_ff @(posedge BRAM_Clk) begin
    if (w_wr_b) begin
      r_mem[w_idx_b] <= w_new_b;
    end
    if (w_wr_a) begin
      r_mem[w_idx_a] <= w_arr_a;
    end
  end

  // Same-word access with at least one writer, flagged the cycle after the edge.
  always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
    if (BRAM_Rst) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_same & (w_wr_a | w_wr_b);
    end
  end

  assign BRAM_Collision = r_collision;

  lmb_bram_port_pipe #(.DW(C_PORT_DWIDTH), .LAT(C_READ_LATENCY)) u_pipe_a (
    .i_clk   (BRAM_Clk),
    .i_rst   (BRAM_Rst),
    .i_acc   (w_acc_a),
    .i_hit   (w_hit_a),
    .i_rdata (w_raw_a),
    .o_din   (w_din_a),
    .o_valid (BRAM_Valid_A),
    .o_err   (BRAM_AddrErr_A)
  );

  lmb_bram_port_pipe #(.DW(C_PORT_DWIDTH), .LAT(C_READ_LATENCY)) u_pipe_b (
    .i_clk   (BRAM_Clk),
    .i_rst   (BRAM_Rst),
    .i_acc   (w_acc_b),
    .i_hit   (w_hit_b),
    .i_rdata (w_raw_b),
    .o_din   (w_din_b),
    .o_valid (BRAM_Valid_B),
    .o_err   (BRAM_AddrErr_B)
  );

  assign BRAM_Din_A = w_din_a;
  assign BRAM_Din_B = w_din_b;

endmodule

// File: tb/tb_lmb_bram_dp_pipelined.sv
// Bench: two instances (latency 1 / WRITE_FIRST and latency 2 / READ_FIRST) share
// stimulus and are checked every cycle against a word-array reference model.
module tb_lmb_bram_dp_pipelined;

  localparam int MAXC = 2048;

  typedef struct packed {
    logic        v;
    logic        err;
    logic [31:0] d;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  wen_a = 4'h0, wen_b = 4'h0;
  logic [31:0] addr_a = 32'h0, addr_b = 32'h0, dout_a = 32'h0, dout_b = 32'h0;

  logic [31:0] din_a [2];
  logic [31:0] din_b [2];
  logic        val_a [2];
  logic        val_b [2];
  logic        err_a [2];
  logic        err_b [2];
  logic        col   [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_from = 0;

  logic [31:0] mdl_mem [int];
  res_t        h_a [2][MAXC];
  res_t        h_b [2][MAXC];
  logic        h_col [MAXC];
  logic [31:0] exp_din_a [2];
  logic [31:0] exp_din_b [2];

  always #5 clk = ~clk;

  lmb_bram_dp_pipelined #(.C_READ_LATENCY(1), .C_RDW_MODE("WRITE_FIRST")) u_dut_wf (
    .BRAM_Clk(clk), .BRAM_Rst(rst),
    .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(dout_a),
    .BRAM_Din_A(din_a[0]), .BRAM_Valid_A(val_a[0]), .BRAM_AddrErr_A(err_a[0]),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(dout_b),
    .BRAM_Din_B(din_b[0]), .BRAM_Valid_B(val_b[0]), .BRAM_AddrErr_B(err_b[0]),
    .BRAM_Collision(col[0])
  );

  lmb_bram_dp_pipelined #(.C_READ_LATENCY(2), .C_RDW_MODE("READ_FIRST")) u_dut_rf (
    .BRAM_Clk(clk), .BRAM_Rst(rst),
    .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(dout_a),
    .BRAM_Din_A(din_a[1]), .BRAM_Valid_A(val_a[1]), .BRAM_AddrErr_A(err_a[1]),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(dout_b),
    .BRAM_Din_B(din_b[1]), .BRAM_Valid_B(val_b[1]), .BRAM_AddrErr_B(err_b[1]),
    .BRAM_Collision(col[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte lane i is bits [8i+7:8i]; wen[3] is the most significant lane.
  function automatic logic [31:0] apply_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] wen);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (wen[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input int idx);
    if (mdl_mem.exists(idx)) return mdl_mem[idx];
    return 32'h0;
  endfunction

  function automatic res_t port_result(input logic acc, input logic hit, input logic [3:0] wen,
                                       input logic [31:0] old_w, input logic [31:0] wd,
                                       input bit write_first);
    res_t r;
    r = '0;
    if (acc) begin
      r.v = 1'b1;
      if (!hit) begin
        r.err = 1'b1;
      end else if (write_first && wen != 4'h0) begin
        r.d = apply_bytes(old_w, wd, wen);
      end else begin
        r.d = old_w;
      end
    end
    return r;
  endfunction

  // Model of one clock edge: results for both modes, then memory update with A last.
  task automatic model_access(input int c);
    logic        acc_a, acc_b, hit_a, hit_b;
    int          ia, ib;
    logic [31:0] old_a, old_b;
    acc_a = !rst && en_a;
    acc_b = !rst && en_b;
    hit_a = addr_a < 32'h0001_0000;
    hit_b = addr_b < 32'h0001_0000;
    ia = int'(addr_a[15:2]);
    ib = int'(addr_b[15:2]);
    old_a = mem_word(ia);
    old_b = mem_word(ib);
    for (int m = 0; m < 2; m++) begin
      h_a[m][c] = port_result(acc_a, hit_a, wen_a, old_a, dout_a, m == 0);
      h_b[m][c] = port_result(acc_b, hit_b, wen_b, old_b, dout_b, m == 0);
    end
    h_col[c] = acc_a && acc_b && hit_a && hit_b && (ia == ib) && ((wen_a | wen_b) != 4'h0);
    if (acc_b && hit_b && wen_b != 4'h0) mdl_mem[ib] = apply_bytes(mem_word(ib), dout_b, wen_b);
    if (acc_a && hit_a && wen_a != 4'h0) mdl_mem[ia] = apply_bytes(mem_word(ia), dout_a, wen_a);
  endtask

  task automatic check_outputs(input int c);
    res_t ra, rb;
    int   e;
    for (int k = 0; k < 2; k++) begin
      e = c - k;
      ra = '0;
      rb = '0;
      if (e >= valid_from && e >= 0) begin
        ra = h_a[k][e];
        rb = h_b[k][e];
      end
      if (ra.v) exp_din_a[k] = ra.d;
      if (rb.v) exp_din_b[k] = rb.d;
      check_eq($sformatf("d%0d_validA@%0d", k, c), {31'b0, val_a[k]}, {31'b0, ra.v});
      check_eq($sformatf("d%0d_errA@%0d", k, c), {31'b0, err_a[k]}, {31'b0, ra.v & ra.err});
      check_eq($sformatf("d%0d_dinA@%0d", k, c), din_a[k], exp_din_a[k]);
      check_eq($sformatf("d%0d_validB@%0d", k, c), {31'b0, val_b[k]}, {31'b0, rb.v});
      check_eq($sformatf("d%0d_errB@%0d", k, c), {31'b0, err_b[k]}, {31'b0, rb.v & rb.err});
      check_eq($sformatf("d%0d_dinB@%0d", k, c), din_b[k], exp_din_b[k]);
      check_eq($sformatf("d%0d_coll@%0d", k, c), {31'b0, col[k]}, {31'b0, h_col[c]});
    end
  endtask

  task automatic step();
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      n_errors++;
    end else begin
      model_access(cyc);
      @(posedge clk);
      #1;
      check_outputs(cyc);
      cyc++;
    end
  endtask

  task automatic set_a(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] d);
    en_a = en; wen_a = wen; addr_a = addr; dout_a = d;
  endtask

  task automatic set_b(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] d);
    en_b = en; wen_b = wen; addr_b = addr; dout_b = d;
  endtask

  task automatic idle();
    set_a(1'b0, 4'h0, 32'h0, 32'h0);
    set_b(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_d%0d_dinA", tag, k), din_a[k], 32'h0);
      check_eq($sformatf("%s_d%0d_dinB", tag, k), din_b[k], 32'h0);
      check_eq($sformatf("%s_d%0d_flags", tag, k),
               {27'b0, val_a[k], val_b[k], err_a[k], err_b[k], col[k]}, 32'h0);
      exp_din_a[k] = 32'h0;
      exp_din_b[k] = 32'h0;
    end
  endtask

  initial begin
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Give every word the random phase can touch a known value.
    for (int w = 0; w < 32; w++) begin
      set_a(1'b1, 4'hF, 32'(w * 4), 32'h0);
      step();
    end
    idle();
    step();

    // Full write then read, then a single-lane update.
    set_a(1'b1, 4'hF, 32'h10, 32'hDEADBEEF); step();
    set_a(1'b1, 4'h0, 32'h10, 32'h0);        step();
    check_eq("t1_wf_read", din_a[0], 32'hDEADBEEF);
    idle(); step();
    check_eq("t1_rf_read", din_a[1], 32'hDEADBEEF);
    set_a(1'b1, 4'b0100, 32'h10, 32'h00AA0000); step();
    set_a(1'b1, 4'h0, 32'h10, 32'h0);           step();
    check_eq("t2_lane", din_a[0], 32'hDEAABEEF);
    idle(); step();

    // Same-port read-during-write on a zero word.
    set_a(1'b1, 4'hF, 32'h20, 32'h12345678); step();
    check_eq("t3_write_first", din_a[0], 32'h12345678);
    idle(); step();
    check_eq("t3_read_first", din_a[1], 32'h0);

    // Dual write to one word, then write/read cross-port.
    set_a(1'b1, 4'b1100, 32'h30, 32'hAAAAAAAA);
    set_b(1'b1, 4'hF, 32'h30, 32'hBBBBBBBB); step();
    check_eq("t4_coll_ww", {31'b0, col[1]}, 32'h1);
    idle(); step();
    check_eq("t4_coll_clear", {31'b0, col[0]}, 32'h0);
    set_a(1'b1, 4'h0, 32'h30, 32'h0); step();
    check_eq("t4_merge", din_a[0], 32'hAAAABBBB);
    set_a(1'b1, 4'hF, 32'h40, 32'h5); step();
    set_a(1'b1, 4'hF, 32'h40, 32'h77777777);
    set_b(1'b1, 4'h0, 32'h40, 32'h0); step();
    check_eq("t4_coll_wr", {31'b0, col[0]}, 32'h1);
    check_eq("t4_b_old", din_b[0], 32'h5);
    idle(); step();

    // Out-of-range write must not alias onto word 0.
    set_a(1'b1, 4'hF, 32'h0001_0000, 32'hFFFFFFFF); step();
    check_eq("t5_err", {31'b0, err_a[0]}, 32'h1);
    check_eq("t5_din", din_a[0], 32'h0);
    set_a(1'b1, 4'h0, 32'h0, 32'h0); step();
    idle(); step();
    check_eq("t5_word0", din_a[1], 32'h0);

    // Back-to-back reads, then a reset landing mid-stream.
    set_a(1'b1, 4'h0, 32'h10, 32'h0); step();
    set_a(1'b1, 4'h0, 32'h20, 32'h0); step();
    set_a(1'b1, 4'h0, 32'h30, 32'h0); step();
    idle(); step(); step(); step();
    set_a(1'b1, 4'h0, 32'h10, 32'h0); step();
    set_a(1'b1, 4'h0, 32'h20, 32'h0); step();
    rst = 1'b1;
    idle();
    #1;
    check_all_zero("midrst");
    valid_from = cyc;
    step(); step();
    rst = 1'b0;
    step(); step();
    set_a(1'b1, 4'h0, 32'h20, 32'h0); step();
    idle(); step();
    check_eq("t6_intact", din_a[1], 32'h12345678);

    // Randomised traffic on a small word set plus occasional misses.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        en   = ($urandom_range(0, 3) != 0);
        wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        addr = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h0001_0000)
                                            : 32'(($urandom_range(0, 31) << 2) | $urandom_range(0, 3));
        if (p == 0) set_a(en, wen, addr, $urandom);
        else        set_b(en, wen, addr, $urandom);
      end
      step();
    end
    idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
